hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS core, sitting between the IF/ID and ID/EX registers. Detects load-use hazards and holds PC and IF/ID for a configurable number of load-latency cycles, injecting bubbles into ID/EX. Flushes wrong-path instructions for a configurable number of cycles after a taken branch. Replaces the single-cycle combinational detection unit with a small sequential controller.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_ctrl_unit_sat_counter.sv | 25 ++
 rtl/hazard_ctrl_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] BUBBLE_INSTR = 32'd0;
    localparam int          REG_ZERO     = 0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter used for hazard statistics (HAZARD_STATS_EN builds).
module sat_counter
    import hazard_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / taken-branch flush controller between IF/ID and ID/EX.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              idex_mem_read_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       instr_i,
    output logic [31:0]       instr_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              ifid_flush_o,
    output logic              busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam int MAX_CYC = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
    localparam int REM_W   = $clog2(MAX_CYC) + 1;

    localparam logic [REM_W-1:0] LOAD_REM  = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYC - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_nxt;
    logic             w_hit;
    logic             w_stall;
    logic             w_flush;

    assign w_hit = idex_mem_read_i && (idex_rt_i != REG_AW'(REG_ZERO)) &&
                   ((idex_rt_i == ifid_rs_i) ||
                    (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // A taken branch overrides everything, including a stall already in progress.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (branch_taken_i) begin
            w_flush = 1'b1;
            if (FLUSH_CYC > 1) begin
                w_state_nxt = FLUSH;
                w_rem_nxt   = FLUSH_REM;
            end else begin
                w_state_nxt = RUN;
                w_rem_nxt   = '0;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hit) begin
                        w_stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = STALL;
                            w_rem_nxt   = LOAD_REM;
                        end
                    end
                end
                STALL: begin
                    w_stall   = 1'b1;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == REM_W'(1)) w_state_nxt = RUN;
                end
                FLUSH: begin
                    w_flush   = 1'b1;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == REM_W'(1)) w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        instr_o       = instr_i;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        busy_o        = (r_state != RUN);
        if (!rst_i) begin
            instr_o       = BUBBLE_INSTR;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            busy_o        = 1'b0;
        end else if (w_flush) begin
            instr_o       = BUBBLE_INSTR;
            idex_bubble_o = 1'b1;
            ifid_flush_o  = 1'b1;
        end else if (w_stall) begin
            instr_o       = BUBBLE_INSTR;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    // w_stall is never set alongside w_flush, so a hit+branch cycle counts as flush only.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_flush),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations driven in parallel, checked
// against a remaining-cycle reference model (counters checked under HAZARD_STATS_EN).
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mr;
    logic [4:0]  irt, rs, rt;
    logic        ur, br;
    logic [31:0] instr_i;

    logic [31:0] instr_a, instr_b;
    logic        pcw_a, ifw_a, bub_a, fl_a, busy_a;
    logic        pcw_b, ifw_b, bub_b, fl_b, busy_b;
`ifdef HAZARD_STATS_EN
    logic [15:0] scnt_a, fcnt_a;
    logic [1:0]  scnt_b, fcnt_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int stall_left [2];
    int flush_left [2];
    int scnt_m     [2];
    int fcnt_m     [2];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(16)) dut_a (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .idex_mem_read_i (mr),
        .idex_rt_i       (irt),
        .ifid_rs_i       (rs),
        .ifid_rt_i       (rt),
        .ifid_uses_rt_i  (ur),
        .branch_taken_i  (br),
        .instr_i         (instr_i),
        .instr_o         (instr_a),
        .pc_write_o      (pcw_a),
        .ifid_write_o    (ifw_a),
        .idex_bubble_o   (bub_a),
        .ifid_flush_o    (fl_a),
        .busy_o          (busy_a)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o     (scnt_a),
        .flush_cnt_o     (fcnt_a)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(2)) dut_b (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .idex_mem_read_i (mr),
        .idex_rt_i       (irt),
        .ifid_rs_i       (rs),
        .ifid_rt_i       (rt),
        .ifid_uses_rt_i  (ur),
        .branch_taken_i  (br),
        .instr_i         (instr_i),
        .instr_o         (instr_b),
        .pc_write_o      (pcw_b),
        .ifid_write_o    (ifw_b),
        .idex_bubble_o   (bub_b),
        .ifid_flush_o    (fl_b),
        .busy_o          (busy_b)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o     (scnt_b),
        .flush_cnt_o     (fcnt_b)
`endif
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int fc_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // kind: 0 = normal, 1 = stall, 2 = flush, 3 = held in reset
    task automatic check_dut(input int k, input int kind, input logic exp_busy);
        logic [31:0] o_instr;
        logic        o_pcw, o_ifw, o_bub, o_fl, o_busy;
        logic [31:0] e_instr;
        string       p;
        p = (k == 0) ? "a." : "b.";
        if (k == 0) begin
            o_instr = instr_a; o_pcw = pcw_a; o_ifw = ifw_a;
            o_bub = bub_a; o_fl = fl_a; o_busy = busy_a;
        end else begin
            o_instr = instr_b; o_pcw = pcw_b; o_ifw = ifw_b;
            o_bub = bub_b; o_fl = fl_b; o_busy = busy_b;
        end
        e_instr = (kind == 0) ? instr_i : 32'd0;
        chk({p, "instr"},     o_instr, e_instr);
        chk({p, "pc_write"},  32'(o_pcw), 32'((kind == 0) || (kind == 2)));
        chk({p, "ifid_write"}, 32'(o_ifw), 32'((kind == 0) || (kind == 2)));
        chk({p, "bubble"},    32'(o_bub), 32'(kind != 0));
        chk({p, "flush"},     32'(o_fl),  32'(kind == 2));
        chk({p, "busy"},      32'(o_busy), 32'(exp_busy));
`ifdef HAZARD_STATS_EN
        if (k == 0) begin
            chk("a.stall_cnt", 32'(scnt_a), 32'(scnt_m[0]));
            chk("a.flush_cnt", 32'(fcnt_a), 32'(fcnt_m[0]));
        end else begin
            chk("b.stall_cnt", 32'(scnt_b), 32'(scnt_m[1]));
            chk("b.flush_cnt", 32'(fcnt_b), 32'(fcnt_m[1]));
        end
`endif
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            stall_left[k] = 0;
            flush_left[k] = 0;
            scnt_m[k]     = 0;
            fcnt_m[k]     = 0;
        end
    endtask

    task automatic cyc(input logic i_mr, input logic [4:0] i_irt, input logic [4:0] i_rs,
                       input logic [4:0] i_rt, input logic i_ur, input logic i_br);
        logic hit;
        logic e_busy;
        int   kind;
        @(negedge clk);
        mr = i_mr; irt = i_irt; rs = i_rs; rt = i_rt; ur = i_ur; br = i_br;
        instr_i = $urandom;
        #1;
        hit = i_mr && (i_irt != 5'd0) && ((i_irt == i_rs) || (i_ur && (i_irt == i_rt)));
        for (int k = 0; k < 2; k++) begin
            e_busy = (stall_left[k] > 0) || (flush_left[k] > 0);
            if (i_br || (flush_left[k] > 0)) kind = 2;
            else if ((stall_left[k] > 0) || hit) kind = 1;
            else kind = 0;
            check_dut(k, kind, e_busy);
            if (i_br) begin
                flush_left[k] = fc_of(k) - 1;
                stall_left[k] = 0;
            end else if (flush_left[k] > 0) begin
                flush_left[k]--;
            end else if (stall_left[k] > 0) begin
                stall_left[k]--;
            end else if (hit) begin
                stall_left[k] = lat_of(k) - 1;
            end
            if ((kind == 1) && (scnt_m[k] < cmax_of(k))) scnt_m[k]++;
            if ((kind == 2) && (fcnt_m[k] < cmax_of(k))) fcnt_m[k]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges, check outputs right away, release a cycle later.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 2; k++) check_dut(k, 3, 1'b0);
        @(negedge clk);
        mr = 1'b0; irt = 5'd0; rs = 5'd0; rt = 5'd0; ur = 1'b0; br = 1'b0;
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        mr = 1'b0; irt = 5'd0; rs = 5'd0; rt = 5'd0; ur = 1'b0; br = 1'b0;
        instr_i = 32'h1234_5678;
        model_clear();
        do_reset();

        // load $t0 (r8) followed by a reader of $t0
        idle(1);
        cyc(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        idle(4);
        // load to $zero, and rt match that is not a source
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc(1'b1, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0);
        idle(3);
        // branch during the second stall cycle
        cyc(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(3);
        // hit and branch together
        cyc(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1);
        idle(3);
        // branch during flush reloads the flush length
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(3);
        // reset in the middle of a stall
        cyc(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        do_reset();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0));
            if (i == 200) do_reset();
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
